// File: rtl/square_rotation_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// square_rotation_ctrl_pkg
//
// Shared definitions for the rotating-square display blocks: segment and
// digit-enable constants, the sequencer state encoding, and small helpers
// for moving the square around its 8-position loop.
//
// Positions 0..3 walk the top half of the display left-to-right and
// positions 4..7 walk the bottom half right-to-left, so the square appears
// to rotate around the four digits.
// -----------------------------------------------------------------------------
package square_rotation_ctrl_pkg;

    // Segment patterns are active low, ordered {dp,a,b,c,d,e,f,g}.
    localparam logic [7:0] SSEG_TOP   = 8'h9C;
    localparam logic [7:0] SSEG_BOT   = 8'hE2;
    localparam logic [7:0] SSEG_BLANK = 8'hFF;

    // Digit enables are active low; all ones turns every digit off.
    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // One step around the loop; the 3-bit arithmetic wraps modulo 8.
    function automatic logic [2:0] next_pos(input logic [2:0] p, input logic cw);
        return cw ? (p + 3'd1) : (p - 3'd1);
    endfunction

    // A lap is completed when the step crosses the 7/0 seam in the
    // direction of travel.
    function automatic logic is_lap(input logic [2:0] p, input logic cw);
        return cw ? (p == 3'd7) : (p == 3'd0);
    endfunction

endpackage

// File: rtl/square_pos_decoder.sv
// -----------------------------------------------------------------------------
// square_pos_decoder
//
// Purely combinational map from a square position to the digit enable and
// segment pattern that draws it. Kept separate so other display blocks can
// reuse it; any registering is left to the instantiating block.
//
// Ports:
//   pos   in  3  square position 0..7
//   blank in  1  1 = show nothing
//   an    out 4  digit enables, active low
//   sseg  out 8  segments, active low, {dp,a,b,c,d,e,f,g}
// -----------------------------------------------------------------------------
module square_pos_decoder
    import square_rotation_ctrl_pkg::*;
(
    input  logic [2:0] pos,
    input  logic       blank,
    output logic [3:0] an,
    output logic [7:0] sseg
);

    // Top half lights digits left-to-right (leftmost digit is an[3]);
    // bottom half comes back right-to-left, so its walking zero starts
    // at an[0] and moves up.
    always_comb begin
        an   = AN_OFF;
        sseg = SSEG_BLANK;
        if (!blank) begin
            if (!pos[2]) begin
                sseg = SSEG_TOP;
                an   = ~(4'b1000 >> pos[1:0]);
            end else begin
                sseg = SSEG_BOT;
                an   = ~(4'b0001 << pos[1:0]);
            end
        end
    end

endmodule

// File: rtl/square_rotation_ctrl.sv
// -----------------------------------------------------------------------------
// square_rotation_ctrl
//
// Sequencer for the rotating-square display on the 4-digit seven-segment
// board. Owns the square position, the step prescaler and a lap counter,
// and drives the digit enables and segments directly.
//
// Parameters:
//   DIV_W  prescaler width; step period is 2^(DIV_W-rate) clocks (>= 4)
//   LAP_W  lap counter width
//
// Ports:
//   clk       in  1      system clock
//   reset     in  1      asynchronous, active-high reset
//   en        in  1      1 = run continuously, 0 = pause
//   cw        in  1      1 = clockwise (pos+1), 0 = counter-clockwise
//   rate      in  2      speed select, larger is faster
//   step      in  1      debounced single-step request, rising edge acts
//   clr       in  1      synchronous clear of position, prescaler, laps
//   an        out 4      digit enables, active low
//   sseg      out 8      segments, active low, {dp,a,b,c,d,e,f,g}
//   pos       out 3      current position
//   laps      out LAP_W  completed laps, wraps
//   lap_tick  out 1      one-cycle pulse on each lap completion
// -----------------------------------------------------------------------------
module square_rotation_ctrl
    import square_rotation_ctrl_pkg::*;
#(
    parameter int DIV_W = 25,
    parameter int LAP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cw,
    input  logic [1:0]       rate,
    input  logic             step,
    input  logic             clr,
    output logic [3:0]       an,
    output logic [7:0]       sseg,
    output logic [2:0]       pos,
    output logic [LAP_W-1:0] laps,
    output logic             lap_tick
);

    localparam logic [DIV_W-1:0] PRESC_ONES = '1;
    localparam logic [DIV_W-1:0] PRESC_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [LAP_W-1:0] LAP_ONE    = {{(LAP_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic             step_q;
    logic             step_edge;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] tick_mask;
    logic             tick;
    logic             advance;
    logic [3:0]       an_dec;
    logic [7:0]       sseg_dec;

    // A faster rate simply looks at fewer low prescaler bits, so changing
    // rate never needs the counter to be reset.
    always_comb begin
        step_edge = step & ~step_q;
        tick_mask = PRESC_ONES >> rate;
        tick      = (state == ST_RUN) && ((presc & tick_mask) == tick_mask);
        advance   = 1'b0;
        if (state == ST_RUN) begin
            advance = tick;
        end else if (state == ST_PAUSE) begin
            advance = step_edge;
        end
    end

    // Sequencer transitions. IDLE is left on the first run request or
    // step edge and only comes back through reset.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end else if (step_edge) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and the step edge history, which is tracked every
    // cycle so a held button only ever counts once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            step_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            step_q <= step;
        end
    end

    // Position, prescaler and lap bookkeeping. A clear wins over any tick
    // or step landing in the same cycle. The advance decided while still
    // in RUN is taken even if en has just dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            pos      <= 3'd0;
            laps     <= '0;
            lap_tick <= 1'b0;
        end else if (clr) begin
            presc    <= '0;
            pos      <= 3'd0;
            laps     <= '0;
            lap_tick <= 1'b0;
        end else begin
            lap_tick <= 1'b0;
            if (state == ST_RUN) begin
                presc <= presc + PRESC_ONE;
            end
            if (advance) begin
                pos <= next_pos(pos, cw);
                if (is_lap(pos, cw)) begin
                    lap_tick <= 1'b1;
                    laps     <= laps + LAP_ONE;
                end
            end
        end
    end

    square_pos_decoder u_decoder (
        .pos   (pos),
        .blank (state == ST_IDLE),
        .an    (an_dec),
        .sseg  (sseg_dec)
    );

    // Display pins are registered so they are glitch-free; they follow
    // pos and state one clock later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an   <= AN_OFF;
            sseg <= SSEG_BLANK;
        end else begin
            an   <= an_dec;
            sseg <= sseg_dec;
        end
    end

endmodule

// File: tb/tb_square_rotation_ctrl.sv
// -----------------------------------------------------------------------------
// tb_square_rotation_ctrl
//
// Self-checking bench for square_rotation_ctrl with a small prescaler.
// A behavioural model tracks the square with plain integer arithmetic and
// a lookup table for the digit enables.
// -----------------------------------------------------------------------------
module tb_square_rotation_ctrl;

    localparam int DIV_W = 4;
    localparam int LAP_W = 8;

    localparam logic [3:0] AN_TAB [8] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110,
                                          4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             en    = 1'b0;
    logic             cw    = 1'b0;
    logic [1:0]       rate  = 2'd0;
    logic             step  = 1'b0;
    logic             clr   = 1'b0;
    logic [3:0]       an;
    logic [7:0]       sseg;
    logic [2:0]       pos;
    logic [LAP_W-1:0] laps;
    logic             lap_tick;

    int total = 0;
    int bad   = 0;

    // Reference model
    int         m_pos;
    int         m_laps;
    int         m_presc;
    bit         m_started;
    bit         m_running;
    bit         m_lap_tick;
    bit         m_step_prev;
    logic [3:0] m_an;
    logic [7:0] m_sseg;

    square_rotation_ctrl #(
        .DIV_W (DIV_W),
        .LAP_W (LAP_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .cw       (cw),
        .rate     (rate),
        .step     (step),
        .clr      (clr),
        .an       (an),
        .sseg     (sseg),
        .pos      (pos),
        .laps     (laps),
        .lap_tick (lap_tick)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pos       = 0;
        m_laps      = 0;
        m_presc     = 0;
        m_started   = 1'b0;
        m_running   = 1'b0;
        m_lap_tick  = 1'b0;
        m_step_prev = 1'b0;
        m_an        = 4'hF;
        m_sseg      = 8'hFF;
    endtask

    // True when the running square is due to move at the coming clock edge.
    function automatic bit tick_due();
        int period;
        period = 1 << (DIV_W - int'(rate));
        return m_running && ((m_presc % period) == (period - 1));
    endfunction

    task automatic model_step();
        bit edge_seen;
        bit adv;
        bit lap;
        if (!m_started) begin
            m_an   = 4'hF;
            m_sseg = 8'hFF;
        end else begin
            m_an   = AN_TAB[m_pos];
            m_sseg = (m_pos < 4) ? 8'h9C : 8'hE2;
        end
        edge_seen  = step && !m_step_prev;
        adv        = m_running ? tick_due() : (m_started && edge_seen);
        m_lap_tick = 1'b0;
        if (clr) begin
            m_pos   = 0;
            m_presc = 0;
            m_laps  = 0;
        end else begin
            if (m_running) m_presc = (m_presc + 1) % (1 << DIV_W);
            if (adv) begin
                lap   = cw ? (m_pos == 7) : (m_pos == 0);
                m_pos = (m_pos + (cw ? 1 : 7)) % 8;
                if (lap) begin
                    m_lap_tick = 1'b1;
                    m_laps     = (m_laps + 1) % (1 << LAP_W);
                end
            end
        end
        if (!m_started) begin
            if (en) begin
                m_started = 1'b1;
                m_running = 1'b1;
            end else if (edge_seen) begin
                m_started = 1'b1;
                m_running = 1'b0;
            end
        end else begin
            m_running = en;
        end
        m_step_prev = step;
    endtask

    function automatic logic [23:0] exp_vec();
        logic [2:0] p;
        logic [7:0] l;
        p = 3'(m_pos);
        l = 8'(m_laps);
        return {m_an, m_sseg, p, l, m_lap_tick};
    endfunction

    // Advance one clock, update the model at the edge, return on the
    // falling edge where outputs are sampled and inputs are changed.
    task automatic clk_step();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clk_step();
        clk_step();
        total++;
        if ({an, sseg, pos, laps, lap_tick} !== {4'hF, 8'hFF, 3'd0, 8'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_state got=%h required=%h",
                     {an, sseg, pos, laps, lap_tick}, {4'hF, 8'hFF, 3'd0, 8'd0, 1'b0});
        end
        reset = 1'b0;
        clk_step();
        total++;
        if ({an, sseg, pos, laps, lap_tick} !== exp_vec()) begin
            bad++;
            $display("[TB] FAIL idle_blank got=%h required=%h", {an, sseg, pos, laps, lap_tick}, exp_vec());
        end
    endtask

    task automatic test_run_cw();
        en   = 1'b1;
        cw   = 1'b1;
        rate = 2'd0;
        for (int i = 0; i < 148; i++) begin
            clk_step();
            total++;
            if ({an, sseg, pos, laps, lap_tick} !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL run_cw cyc=%0d got=%h required=%h", i, {an, sseg, pos, laps, lap_tick}, exp_vec());
            end
        end
        total++;
        if (laps !== 8'd1) begin
            bad++;
            $display("[TB] FAIL run_cw_laps got=%0d required=1", laps);
        end
    endtask

    task automatic test_rate();
        int changes;
        logic [2:0] prev;
        rate = 2'd2;
        for (int i = 0; i < 40; i++) begin
            clk_step();
            total++;
            if ({an, sseg, pos, laps, lap_tick} !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL rate2 cyc=%0d got=%h required=%h", i, {an, sseg, pos, laps, lap_tick}, exp_vec());
            end
        end
        rate    = 2'd3;
        changes = 0;
        prev    = 3'(m_pos);
        for (int i = 0; i < 24; i++) begin
            clk_step();
            if (3'(m_pos) != prev) changes++;
            prev = 3'(m_pos);
            total++;
            if ({an, sseg, pos, laps, lap_tick} !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL rate3 cyc=%0d got=%h required=%h", i, {an, sseg, pos, laps, lap_tick}, exp_vec());
            end
        end
        total++;
        if (changes != 12) begin
            bad++;
            $display("[TB] FAIL rate3_period got=%0d moves required=12", changes);
        end
    endtask

    task automatic test_ccw();
        bit seen;
        seen = 1'b0;
        cw   = 1'b0;
        rate = 2'd3;
        for (int i = 0; i < 200 && !seen; i++) begin
            clk_step();
            if (lap_tick === 1'b1) seen = 1'b1;
            total++;
            if ({an, sseg, pos, laps, lap_tick} !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL ccw cyc=%0d got=%h required=%h", i, {an, sseg, pos, laps, lap_tick}, exp_vec());
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL ccw_lap_timeout got=no lap_tick required=lap_tick within 200 cycles");
        end
        for (int i = 0; i < 6; i++) begin
            clk_step();
            total++;
            if ({an, sseg, pos, laps, lap_tick} !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL ccw_after cyc=%0d got=%h required=%h", i, {an, sseg, pos, laps, lap_tick}, exp_vec());
            end
        end
    endtask

    task automatic test_pause_step();
        int p0;
        en = 1'b0;
        cw = 1'b1;
        clk_step();
        clk_step();
        p0 = m_pos;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                step = (i < 2);
                clk_step();
                total++;
                if ({an, sseg, pos, laps, lap_tick} !== exp_vec()) begin
                    bad++;
                    $display("[TB] FAIL pause_step k=%0d got=%h required=%h", k, {an, sseg, pos, laps, lap_tick}, exp_vec());
                end
            end
        end
        total++;
        if (pos !== 3'((p0 + 3) % 8)) begin
            bad++;
            $display("[TB] FAIL pause_three_steps got=%0d required=%0d", pos, (p0 + 3) % 8);
        end
        for (int i = 0; i < 8; i++) begin
            step = (i < 6);
            clk_step();
            total++;
            if ({an, sseg, pos, laps, lap_tick} !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL step_held cyc=%0d got=%h required=%h", i, {an, sseg, pos, laps, lap_tick}, exp_vec());
            end
        end
        total++;
        if (pos !== 3'((p0 + 4) % 8)) begin
            bad++;
            $display("[TB] FAIL step_held_once got=%0d required=%0d", pos, (p0 + 4) % 8);
        end
        en   = 1'b1;
        rate = 2'd0;
        for (int i = 0; i < 12; i++) begin
            step = i[1];
            clk_step();
            total++;
            if ({an, sseg, pos, laps, lap_tick} !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL step_in_run cyc=%0d got=%h required=%h", i, {an, sseg, pos, laps, lap_tick}, exp_vec());
            end
        end
        step = 1'b0;
    endtask

    task automatic test_clr_tick();
        bit found;
        found = 1'b0;
        en    = 1'b1;
        cw    = 1'b1;
        rate  = 2'd3;
        clr   = 1'b1;
        clk_step();
        clr = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (m_pos == 6 && m_laps == 3 && tick_due()) begin
                found = 1'b1;
            end else begin
                clk_step();
                total++;
                if ({an, sseg, pos, laps, lap_tick} !== exp_vec()) begin
                    bad++;
                    $display("[TB] FAIL clr_setup cyc=%0d got=%h required=%h", i, {an, sseg, pos, laps, lap_tick}, exp_vec());
                end
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL clr_setup_timeout got=not reached required=pos 6 laps 3 with tick");
        end
        clr = 1'b1;
        clk_step();
        clr = 1'b0;
        total++;
        if ({pos, laps, lap_tick} !== {3'd0, 8'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL clr_on_tick got=%h required=%h", {pos, laps, lap_tick}, {3'd0, 8'd0, 1'b0});
        end
        for (int i = 0; i < 6; i++) begin
            clk_step();
            total++;
            if ({an, sseg, pos, laps, lap_tick} !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL clr_after cyc=%0d got=%h required=%h", i, {an, sseg, pos, laps, lap_tick}, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        en   = 1'b1;
        rate = 2'd3;
        for (int i = 0; i < 5; i++) clk_step();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({an, sseg, pos, laps} !== {4'hF, 8'hFF, 3'd0, 8'd0}) begin
            bad++;
            $display("[TB] FAIL async_reset got=%h required=%h", {an, sseg, pos, laps}, {4'hF, 8'hFF, 3'd0, 8'd0});
        end
        model_reset();
        en = 1'b0;
        clk_step();
        reset = 1'b0;
        clk_step();
        step = 1'b1;
        clk_step();
        step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            total++;
            if ({an, sseg, pos, laps, lap_tick} !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL step_from_idle cyc=%0d got=%h required=%h", i, {an, sseg, pos, laps, lap_tick}, exp_vec());
            end
        end
        total++;
        if ({an, sseg, pos} !== {4'b0111, 8'h9C, 3'd0}) begin
            bad++;
            $display("[TB] FAIL idle_step_reveal got=%h required=%h", {an, sseg, pos}, {4'b0111, 8'h9C, 3'd0});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            cw   = 1'($urandom);
            rate = 2'($urandom);
            step = 1'($urandom);
            clr  = ($urandom_range(0, 40) == 0);
            clk_step();
            total++;
            if ({an, sseg, pos, laps, lap_tick} !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL random cyc=%0d got=%h required=%h", i, {an, sseg, pos, laps, lap_tick}, exp_vec());
            end
        end
        clr  = 1'b0;
        step = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run_cw();
        test_rate();
        test_ccw();
        test_pause_step();
        test_clr_tick();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/square_rotation_ctrl.md
Name: square_rotation_ctrl

Overview:
- Sequencer for the rotating-square display on the 4-digit seven-segment board.
- Owns the square's position (8 positions: top half left-to-right, then bottom half right-to-left) and the step prescaler.
- Drives an/sseg directly, with run/pause, direction, speed select, single-step and clear controls plus a lap counter.
- Sits between board switches/debounced buttons and the seven-segment pins.

Parameters:
- DIV_W, 25, prescaler width; step period = 2^(DIV_W-rate) clk cycles; must be >= 4.
- LAP_W, 8, lap counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  level; 1 = run continuously, 0 = pause
- cw  in  1  direction; 1 = clockwise (pos+1), 0 = counter-clockwise (pos-1)
- rate  in  2  speed select; larger = faster
- step  in  1  single-step request, synchronous and debounced; acted on at rising edge
- clr  in  1  synchronous clear of position, prescaler and laps
- an  out  4  digit enables, active low
- sseg  out  8  segments, active low, {dp,a,b,c,d,e,f,g}
- pos  out  3  current position
- laps  out  LAP_W  completed laps, wraps modulo 2^LAP_W
- lap_tick  out  1  one-cycle pulse on a lap completion

Behaviour:
- Reset values:
  - state = IDLE, pos = 0, prescaler = 0, laps = 0, lap_tick = 0, step edge register = 0.
  - an = 4'b1111, sseg = 8'hFF (blank).
- States: IDLE, RUN, PAUSE.
  - IDLE -> RUN when en = 1.
  - IDLE -> PAUSE on a step edge. That edge does not move pos; it only reveals pos 0.
  - RUN -> PAUSE when en = 0.
  - PAUSE -> RUN when en = 1.
  - IDLE is never re-entered except by reset.
- Step edge detection: step_edge = step & ~step_q; step_q is registered every cycle.
- Prescaler:
  - Increments only in RUN; holds its value in PAUSE and IDLE.
  - tick = 1 when the low (DIV_W-rate) bits are all ones.
  - The counter wraps naturally. A rate change takes effect immediately, with no reset of the counter.
- Position advance:
  - In RUN on tick; in PAUSE on step_edge. A step_edge in RUN is ignored.
  - Move is pos+1 if cw, else pos-1, modulo 8.
  - If en falls in the same cycle as a tick, the advance is still taken; the state becomes PAUSE on the next cycle.
- Lap detection:
  - A lap is an advance 7->0 when cw = 1, or 0->7 when cw = 0.
  - On a lap, lap_tick = 1 for exactly one cycle (the cycle after the advance edge) and laps increments, wrapping.
- clr priority:
  - clr has highest priority after reset: pos <= 0, prescaler <= 0, laps <= 0, and any coincident tick or step is dropped.
  - State is unchanged. lap_tick is 0 that cycle.
- Output decode (registered, one cycle after pos/state change):
  - pos 0..3: sseg = 8'h9C (top square); an = 0111, 1011, 1101, 1110 respectively.
  - pos 4..7: sseg = 8'hE2 (bottom square); an = 1110, 1101, 1011, 0111 respectively.
  - IDLE: an = 1111, sseg = 8'hFF.
- A direction change takes effect on the next advance; the prescaler is not disturbed.
- An asynchronous reset mid-run blanks the outputs and zeroes all counters immediately.

Decomposition:
- Shared include holds:
  - SSEG_TOP = 8'h9C, SSEG_BOT = 8'hE2, SSEG_BLANK = 8'hFF, AN_OFF = 4'b1111.
  - State encodings ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2.
- One combinational sub-module, square_pos_decoder (pos, blank -> an, sseg), is reused by future display blocks. Registering of an/sseg stays in the controller.

Test Plan:
(All scenarios use DIV_W = 4.)
- Reset, then en = 1, cw = 1, rate = 0 -> outputs blank until RUN. pos advances every 16 cycles: 0,1,..,7,0. After the 7->0 advance, lap_tick pulses once and laps = 1. an/sseg at pos 5 = 1101/E2, one cycle after pos.
- rate = 2 while running -> advance period becomes 4 cycles without a prescaler reset; rate = 3 -> period 2.
- cw = 0 from pos 0 -> next advance gives pos 7, lap_tick = 1, laps increments; at pos 7, an = 0111, sseg = E2.
- en = 0 (PAUSE), three step pulses of 2 cycles each -> pos advances exactly 3; step held high counts once; step pulses while en = 1 have no effect.
- clr asserted in the same cycle as a tick at pos 6 with laps = 3 -> pos = 0, laps = 0, no lap_tick, and the state stays RUN.
- Assert reset asynchronously mid-run (between clk edges) -> an = 1111, sseg = FF, pos = 0, laps = 0 immediately. Afterwards, a step edge with en = 0 enters PAUSE showing pos 0 (0111/9C) without advancing.
